pipeline_control: RTL and testbench

Hazard and sequencing controller for the five-stage MIPS pipeline. Drives the write enables, bubbles and flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers around the execute stage. Also selects the execute-stage operand forwarding sources. Resolves three sources of hazard:
- load-use dependencies, with a multi-cycle stall counter;
- taken jumps/branches reported by execute, by flush and redirect;
- a busy data memory, by a full-pipeline freeze.

---
 rtl/pipeline_control_if.sv | 31 +++
 rtl/pipeline_control.sv | 73 +++++++
 tb/tb_pipeline_control.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_if.sv
// pipeline_control_if: hazard inputs and pipeline-register controls for pipeline_control.
// PIPE_CTRL_PERFCNT_EN adds the stall_cycles/flush_count counter outputs.
interface pipeline_control_if;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic [7:0] ex_signals;
    logic id_uses_rt, ex_jump, mem_reg_write, wb_reg_write, mem_busy;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic pc_sel, if_id_flush, id_ex_bubble, stalled;
    logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_CTRL_PERFCNT_EN
    logic [15:0] stall_cycles, flush_count;
`endif
    modport master(
`ifdef PIPE_CTRL_PERFCNT_EN
        input stall_cycles, flush_count,
`endif
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_dest, ex_signals, ex_jump,
        output mem_dest, wb_dest, mem_reg_write, wb_reg_write, mem_busy,
        input pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        input pc_sel, if_id_flush, id_ex_bubble, fwd_a, fwd_b, stalled
    );
    modport slave(
`ifdef PIPE_CTRL_PERFCNT_EN
        output stall_cycles, flush_count,
`endif
        input id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_dest, ex_signals, ex_jump,
        input mem_dest, wb_dest, mem_reg_write, wb_reg_write, mem_busy,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
        output pc_sel, if_id_flush, id_ex_bubble, fwd_a, fwd_b, stalled
    );
endinterface

// File: rtl/pipeline_control.sv
// pipeline_control: load-use stall, jump flush, memory freeze and forwarding for the 5-stage MIPS pipe.
// PIPE_CTRL_PERFCNT_EN adds saturating stall_cycles/flush_count counters.
module pipeline_control #(
    parameter int LOAD_LATENCY = 1
) (
    input logic clock,
    input logic reset,
    pipeline_control_if.slave bus
);
    typedef enum logic {RUN, STALL} state_t;
    state_t state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic load_use, live, jump, hold;
    logic unused_ex_bits;
    assign unused_ex_bits = &{1'b0, bus.ex_signals[7:5], bus.ex_signals[3:0]};
    assign load_use = bus.ex_signals[4] && bus.ex_dest != 5'd0 &&
        (bus.ex_dest == bus.id_rs || (bus.id_uses_rt && bus.ex_dest == bus.id_rt));
    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic mw, input logic [4:0] md,
                                           input logic ww, input logic [4:0] wd);
        return (mw && md != 5'd0 && md == r) ? 2'd1 : (ww && wd != 5'd0 && wd == r) ? 2'd2 : 2'd0;
    endfunction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // a busy memory freezes everything, including the stall countdown
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!bus.mem_busy && state == STALL) begin
            state_nxt = (cnt == 3'd0) ? RUN : STALL;
            cnt_nxt   = (cnt == 3'd0) ? cnt : cnt - 3'd1;
        end else if (!bus.mem_busy && !bus.ex_jump && load_use && LOAD_LATENCY > 1) begin
            state_nxt = STALL;
            cnt_nxt   = 3'(LOAD_LATENCY - 2);
        end
    end
    always_comb begin
        live              = reset && !bus.mem_busy;
        jump              = live && state == RUN && bus.ex_jump;
        hold              = live && (state == STALL || (!bus.ex_jump && load_use));
        bus.pc_write      = live && !hold;
        bus.if_id_write   = live && !hold;
        bus.id_ex_write   = live;
        bus.ex_mem_write  = live;
        bus.mem_wb_write  = live;
        bus.pc_sel        = jump;
        bus.if_id_flush   = jump;
        bus.id_ex_bubble  = jump || hold;
        bus.stalled       = reset && (state == STALL || bus.mem_busy);
        bus.fwd_a = reset ? fwd_sel(bus.ex_rs, bus.mem_reg_write, bus.mem_dest, bus.wb_reg_write, bus.wb_dest) : 2'd0;
        bus.fwd_b = reset ? fwd_sel(bus.ex_rt, bus.mem_reg_write, bus.mem_dest, bus.wb_reg_write, bus.wb_dest) : 2'd0;
    end
`ifdef PIPE_CTRL_PERFCNT_EN
    logic [15:0] stall_q, flush_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            stall_q <= (!bus.pc_write && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
            flush_q <= (bus.if_id_flush && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;
        end
    end
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
`endif
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed checks of LOAD_LATENCY=1 and =3 controllers driven in lockstep.
module tb_pipeline_control;
    logic clock = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    pipeline_control_if if1();
    pipeline_control_if if3();
    pipeline_control #(.LOAD_LATENCY(1)) u1 (.clock(clock), .reset(reset), .bus(if1.slave));
    pipeline_control #(.LOAD_LATENCY(3)) u3 (.clock(clock), .reset(reset), .bus(if3.slave));
    always #5 clock = ~clock;
    assign if3.id_rs = if1.id_rs;
    assign if3.id_rt = if1.id_rt;
    assign if3.id_uses_rt = if1.id_uses_rt;
    assign if3.ex_rs = if1.ex_rs;
    assign if3.ex_rt = if1.ex_rt;
    assign if3.ex_dest = if1.ex_dest;
    assign if3.ex_signals = if1.ex_signals;
    assign if3.ex_jump = if1.ex_jump;
    assign if3.mem_dest = if1.mem_dest;
    assign if3.wb_dest = if1.wb_dest;
    assign if3.mem_reg_write = if1.mem_reg_write;
    assign if3.wb_reg_write = if1.wb_reg_write;
    assign if3.mem_busy = if1.mem_busy;
    // {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write, pc_sel, if_id_flush, id_ex_bubble, stalled}
    localparam logic [8:0] ALL0  = 9'b000000000;
    localparam logic [8:0] RUNV  = 9'b111110000;
    localparam logic [8:0] LUV   = 9'b001110010;
    localparam logic [8:0] STLV  = 9'b001110011;
    localparam logic [8:0] JMPV  = 9'b111111110;
    localparam logic [8:0] BUSYV = 9'b000000001;
    function automatic logic [8:0] o1();
        return {if1.pc_write, if1.if_id_write, if1.id_ex_write, if1.ex_mem_write, if1.mem_wb_write,
                if1.pc_sel, if1.if_id_flush, if1.id_ex_bubble, if1.stalled};
    endfunction
    function automatic logic [8:0] o3();
        return {if3.pc_write, if3.if_id_write, if3.id_ex_write, if3.ex_mem_write, if3.mem_wb_write,
                if3.pc_sel, if3.if_id_flush, if3.id_ex_bubble, if3.stalled};
    endfunction
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask
    task automatic idle();
        if1.id_rs = 5'd0; if1.id_rt = 5'd0; if1.id_uses_rt = 1'b0;
        if1.ex_rs = 5'd0; if1.ex_rt = 5'd0; if1.ex_dest = 5'd0; if1.ex_signals = 8'h00;
        if1.ex_jump = 1'b0; if1.mem_dest = 5'd0; if1.wb_dest = 5'd0;
        if1.mem_reg_write = 1'b0; if1.wb_reg_write = 1'b0; if1.mem_busy = 1'b0;
    endtask
    task automatic lw_rs8();
        idle();
        if1.ex_signals = 8'h30; if1.ex_dest = 5'd8; if1.id_rs = 5'd8;
    endtask
    initial begin
        reset = 1'b0;
        idle();
        if1.mem_reg_write = 1'b1; if1.mem_dest = 5'd5; if1.ex_rs = 5'd5;
        #2;
        chk("rst_out1", 16'(o1()), 16'(ALL0));
        chk("rst_out3", 16'(o3()), 16'(ALL0));
        chk("rst_fwd_a", 16'(if1.fwd_a), 16'd0);
        @(negedge clock); #1;
        chk("rst_hold3", 16'(o3()), 16'(ALL0));
        @(negedge clock); reset = 1'b1; idle(); #1;
        chk("run1", 16'(o1()), 16'(RUNV));
        chk("run3", 16'(o3()), 16'(RUNV));
        // load-use on rs: one bubble at latency 1, three at latency 3
        @(negedge clock); lw_rs8(); #1;
        chk("lu1", 16'(o1()), 16'(LUV));
        chk("lu3", 16'(o3()), 16'(LUV));
        @(negedge clock); idle(); #1;
        chk("lu1_done", 16'(o1()), 16'(RUNV));
        chk("lu3_s1", 16'(o3()), 16'(STLV));
        @(negedge clock); idle(); #1;
        chk("lu3_s2", 16'(o3()), 16'(STLV));
        @(negedge clock); idle(); #1;
        chk("lu3_done", 16'(o3()), 16'(RUNV));
`ifdef PIPE_CTRL_PERFCNT_EN
        chk("stall_cnt1_a", if1.stall_cycles, 16'd1);
        chk("stall_cnt3_a", if3.stall_cycles, 16'd3);
`endif
        // non-hazards: rt not an operand, no MemRead, destination $0
        @(negedge clock); idle(); if1.ex_signals = 8'h30; if1.ex_dest = 5'd8; if1.id_rt = 5'd8; #1;
        chk("rt_unused", 16'(o1()), 16'(RUNV));
        @(negedge clock); idle(); if1.ex_signals = 8'h20; if1.ex_dest = 5'd8; if1.id_rs = 5'd8; #1;
        chk("no_memread", 16'(o1()), 16'(RUNV));
        @(negedge clock); idle(); if1.ex_signals = 8'h30; #1;
        chk("dest_zero", 16'(o3()), 16'(RUNV));
        // rt hazard, then memory busy for 4 cycles while latency-3 unit sits in STALL cnt=1
        @(negedge clock); idle(); if1.ex_signals = 8'h30; if1.ex_dest = 5'd8; if1.id_rt = 5'd8; if1.id_uses_rt = 1'b1; #1;
        chk("rt_lu1", 16'(o1()), 16'(LUV));
        chk("rt_lu3", 16'(o3()), 16'(LUV));
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); idle(); if1.mem_busy = 1'b1; #1;
            chk($sformatf("busy1_%0d", i), 16'(o1()), 16'(BUSYV));
            chk($sformatf("busy3_%0d", i), 16'(o3()), 16'(BUSYV));
        end
        @(negedge clock); idle(); #1;
        chk("rel1", 16'(o1()), 16'(RUNV));
        chk("rel3_a", 16'(o3()), 16'(STLV));
        @(negedge clock); idle(); #1;
        chk("rel3_b", 16'(o3()), 16'(STLV));
        @(negedge clock); idle(); #1;
        chk("rel3_done", 16'(o3()), 16'(RUNV));
`ifdef PIPE_CTRL_PERFCNT_EN
        chk("stall_cnt1_b", if1.stall_cycles, 16'd6);
        chk("stall_cnt3_b", if3.stall_cycles, 16'd10);
        chk("flush_cnt3_a", if3.flush_count, 16'd0);
`endif
        // jump beats load-use
        @(negedge clock); lw_rs8(); if1.ex_jump = 1'b1; #1;
        chk("jlu1", 16'(o1()), 16'(JMPV));
        chk("jlu3", 16'(o3()), 16'(JMPV));
        @(negedge clock); idle(); #1;
        chk("jlu3_after", 16'(o3()), 16'(RUNV));
`ifdef PIPE_CTRL_PERFCNT_EN
        chk("flush_cnt3_b", if3.flush_count, 16'd1);
`endif
        // jump under mem_busy is deferred until memory is ready
        @(negedge clock); idle(); if1.ex_jump = 1'b1; if1.mem_busy = 1'b1; #1;
        chk("jbusy3", 16'(o3()), 16'(BUSYV));
        @(negedge clock); idle(); if1.ex_jump = 1'b1; #1;
        chk("jbusy3_rel", 16'(o3()), 16'(JMPV));
        // jump ignored in STALL
        @(negedge clock); lw_rs8(); #1;
        chk("lu3_b", 16'(o3()), 16'(LUV));
        @(negedge clock); idle(); if1.ex_jump = 1'b1; #1;
        chk("stall_jump3", 16'(o3()), 16'(STLV));
        chk("stall_jump1", 16'(o1()), 16'(JMPV));
        // asynchronous reset mid-STALL
        @(negedge clock); idle(); reset = 1'b0; #1;
        chk("areset3", 16'(o3()), 16'(ALL0));
`ifdef PIPE_CTRL_PERFCNT_EN
        chk("areset_cnt3", if3.stall_cycles, 16'd0);
`endif
        @(negedge clock); reset = 1'b1; #1;
        chk("areset3_run", 16'(o3()), 16'(RUNV));
        // forwarding
        @(negedge clock); idle();
        if1.mem_reg_write = 1'b1; if1.wb_reg_write = 1'b1; if1.mem_dest = 5'd5; if1.wb_dest = 5'd5;
        if1.ex_rs = 5'd5; if1.ex_rt = 5'd5; #1;
        chk("fwd_a_mem", 16'(if1.fwd_a), 16'd1);
        chk("fwd_b_mem", 16'(if1.fwd_b), 16'd1);
        if1.mem_reg_write = 1'b0; #1;
        chk("fwd_a_wb", 16'(if1.fwd_a), 16'd2);
        chk("fwd_b_wb", 16'(if1.fwd_b), 16'd2);
        if1.ex_rs = 5'd0; #1;
        chk("fwd_a_zero", 16'(if1.fwd_a), 16'd0);
        if1.mem_reg_write = 1'b1; if1.mem_dest = 5'd6; #1;
        chk("fwd_b_wb_other_mem", 16'(if1.fwd_b), 16'd2);
        if1.mem_dest = 5'd0; if1.wb_reg_write = 1'b0; if1.ex_rt = 5'd0; #1;
        chk("fwd_b_dest0", 16'(if1.fwd_b), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
